// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Opcodes, fetch FSM states and defaults shared by the MIPS core
// Rev     : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module : next_pc_logic
// Brief  : Sequential / BEQ / J next-PC selection (J has highest priority)
// Rev    : 1.0
// ============================================================================
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;

    assign pc_plus4     = pc + 32'd4;
    assign w_br_offset  = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_br_target  = pc_plus4 + w_br_offset;
    assign w_jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (instr[31:26] == OP_J) begin
            next_pc = w_jmp_target;
        end else if (branch && alu_zero) begin
            next_pc = w_br_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : MIPS fetch stage - PC, imem req/ack handshake, held instruction
// Rev    : 1.0
// ============================================================================
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        retire,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;

    logic        w_fetch_done;
    logic        w_retire_now;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;

    next_pc_logic u_next_pc (
        .pc       (r_pc),
        .instr    (r_instr),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (w_next_pc),
        .pc_plus4 (w_pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // imem_req depends on state alone so it stays stable across wait states.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        w_fetch_done = 1'b0;
        w_retire_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    w_retire_now = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_fetch_done) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_retire_now) begin
                r_pc          <= w_next_pc;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign opcode      = r_instr[31:26];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed self-checking bench; three DUTs with different RESET_PC
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [3];
    logic        imem_ack    [3];
    logic [31:0] imem_rdata  [3];
    logic        retire      [3];
    logic        branch      [3];
    logic        alu_zero    [3];
    logic        imem_req    [3];
    logic [31:0] imem_addr   [3];
    logic [31:0] instr       [3];
    logic        instr_valid [3];
    logic [5:0]  opcode      [3];
    logic [31:0] pc          [3];
    logic [31:0] pc_plus4    [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam logic [31:0] C_RPC = (k == 0) ? 32'h0000_0000 :
                                        (k == 1) ? 32'h4000_0020 : 32'hFFFF_FFFC;
        instr_fetch #(.RESET_PC(C_RPC)) u_dut (
            .clk         (clk),
            .rst         (rst[k]),
            .imem_req    (imem_req[k]),
            .imem_addr   (imem_addr[k]),
            .imem_ack    (imem_ack[k]),
            .imem_rdata  (imem_rdata[k]),
            .retire      (retire[k]),
            .branch      (branch[k]),
            .alu_zero    (alu_zero[k]),
            .instr       (instr[k]),
            .instr_valid (instr_valid[k]),
            .opcode      (opcode[k]),
            .pc          (pc[k]),
            .pc_plus4    (pc_plus4[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called in S_REQ; acks with a zero-wait response.
    task automatic fetch(input int k, input logic [31:0] word);
        check("req_before_ack", {31'd0, imem_req[k]}, 32'd1);
        imem_ack[k]   = 1'b1;
        imem_rdata[k] = word;
        tick();
        imem_ack[k]   = 1'b0;
        imem_rdata[k] = 32'h0;
        check("valid_after_ack", {31'd0, instr_valid[k]}, 32'd1);
        check("instr_latched", instr[k], word);
    endtask

    task automatic retire_instr(input int k, input logic br, input logic az);
        retire[k]   = 1'b1;
        branch[k]   = br;
        alu_zero[k] = az;
        tick();
        retire[k]   = 1'b0;
        branch[k]   = 1'b0;
        alu_zero[k] = 1'b0;
        check("valid_after_retire", {31'd0, instr_valid[k]}, 32'd0);
        check("req_after_retire", {31'd0, imem_req[k]}, 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]        = 1'b1;
            imem_ack[k]   = 1'b0;
            imem_rdata[k] = 32'h0;
            retire[k]     = 1'b0;
            branch[k]     = 1'b0;
            alu_zero[k]   = 1'b0;
        end
        tick();
        tick();

        // Reset values
        check("rst_req", {31'd0, imem_req[0]}, 32'd0);
        check("rst_valid", {31'd0, instr_valid[0]}, 32'd0);
        check("rst_addr", imem_addr[0], 32'h0);
        check("rst_pc_plus4", pc_plus4[0], 32'h4);
        check("rst_opcode", {26'd0, opcode[0]}, 32'd0);
        check("rst_instr", instr[0], 32'h0);

        // First fetch
        rst[0] = 1'b0;
        tick();
        check("first_req", {31'd0, imem_req[0]}, 32'd1);
        check("first_addr", imem_addr[0], 32'h0);
        fetch(0, 32'h8C08_0004);
        check("lw_opcode", {26'd0, opcode[0]}, 32'd35);
        check("lw_pc", pc[0], 32'h0);
        check("lw_pc_plus4", pc_plus4[0], 32'h4);
        check("exec_req_low", {31'd0, imem_req[0]}, 32'd0);

        // Ack outside S_REQ must not overwrite instr
        imem_ack[0]   = 1'b1;
        imem_rdata[0] = 32'hFFFF_FFFF;
        tick();
        imem_ack[0]   = 1'b0;
        imem_rdata[0] = 32'h0;
        check("stray_ack_instr", instr[0], 32'h8C08_0004);

        // Sequential retire, then 3 wait states with ignored retire pulses
        retire_instr(0, 1'b0, 1'b0);
        check("seq_addr", imem_addr[0], 32'h4);
        for (int i = 0; i < 3; i++) begin
            retire[0] = (i != 1);
            tick();
            retire[0] = 1'b0;
            check("wait_req", {31'd0, imem_req[0]}, 32'd1);
            check("wait_addr", imem_addr[0], 32'h4);
            check("wait_valid", {31'd0, instr_valid[0]}, 32'd0);
        end
        fetch(0, 32'h0000_0020);
        retire_instr(0, 1'b0, 1'b0);
        check("seq_addr8", imem_addr[0], 32'h8);
        fetch(0, 32'h0000_0020);
        retire_instr(0, 1'b0, 1'b0);
        fetch(0, 32'h0000_0020);
        retire_instr(0, 1'b0, 1'b0);
        check("seq_addr10", imem_addr[0], 32'h10);

        // BEQ taken: 0x14 - 8 = 0xC
        fetch(0, 32'h1000_FFFE);
        check("beq_pc", pc[0], 32'h10);
        retire_instr(0, 1'b1, 1'b1);
        check("beq_taken_addr", imem_addr[0], 32'h0C);
        fetch(0, 32'h0000_0020);
        retire_instr(0, 1'b0, 1'b0);
        // BEQ not taken
        fetch(0, 32'h1000_FFFE);
        retire_instr(0, 1'b1, 1'b0);
        check("beq_not_taken_addr", imem_addr[0], 32'h14);

        // Reset during an S_REQ wait state
        tick();
        check("pre_rst_req", {31'd0, imem_req[0]}, 32'd1);
        rst[0] = 1'b1;
        tick();
        check("midreq_rst_req", {31'd0, imem_req[0]}, 32'd0);
        check("midreq_rst_valid", {31'd0, instr_valid[0]}, 32'd0);
        check("midreq_rst_pc", pc[0], 32'h0);
        rst[0] = 1'b0;
        tick();
        check("refetch_addr", imem_addr[0], 32'h0);
        fetch(0, 32'h0000_0020);

        // Reset wins over simultaneous retire
        rst[0]    = 1'b1;
        retire[0] = 1'b1;
        tick();
        rst[0]    = 1'b0;
        retire[0] = 1'b0;
        check("exec_rst_pc", pc[0], 32'h0);
        check("exec_rst_valid", {31'd0, instr_valid[0]}, 32'd0);
        check("exec_rst_req", {31'd0, imem_req[0]}, 32'd0);

        // Jump priority over taken branch
        rst[1] = 1'b0;
        tick();
        check("j_first_addr", imem_addr[1], 32'h4000_0020);
        fetch(1, 32'h0800_0010);
        check("j_opcode", {26'd0, opcode[1]}, 32'd2);
        retire_instr(1, 1'b1, 1'b1);
        check("j_target_addr", imem_addr[1], 32'h4000_0040);

        // Sequential wrap at top of address space
        rst[2] = 1'b0;
        tick();
        check("wrap_first_addr", imem_addr[2], 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4[2], 32'h0);
        fetch(2, 32'h0000_0020);
        retire_instr(2, 1'b0, 1'b0);
        check("wrap_addr", imem_addr[2], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
